// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes, the multiply/divide FSM state type and the
// M-extension decode helpers. These definitions are shared by the ALU
// decoder and the execute-stage units.
package alu_pkg;

   localparam int ALUCTR_W = 5;

   // Base integer ALU operations
   localparam logic [ALUCTR_W-1:0] ALU_ADD    = 5'b00000;
   localparam logic [ALUCTR_W-1:0] ALU_SUB    = 5'b00001;
   localparam logic [ALUCTR_W-1:0] ALU_AND    = 5'b00010;
   localparam logic [ALUCTR_W-1:0] ALU_OR     = 5'b00011;
   localparam logic [ALUCTR_W-1:0] ALU_XOR    = 5'b00100;
   localparam logic [ALUCTR_W-1:0] ALU_SLT    = 5'b00101;
   localparam logic [ALUCTR_W-1:0] ALU_SLTU   = 5'b00110;
   localparam logic [ALUCTR_W-1:0] ALU_SLL    = 5'b00111;
   localparam logic [ALUCTR_W-1:0] ALU_SRL    = 5'b01000;
   localparam logic [ALUCTR_W-1:0] ALU_SRA    = 5'b01001;

   // RV32M operations
   localparam logic [ALUCTR_W-1:0] ALU_MUL    = 5'b01010;
   localparam logic [ALUCTR_W-1:0] ALU_MULH   = 5'b01011;
   localparam logic [ALUCTR_W-1:0] ALU_MULHSU = 5'b01100;
   localparam logic [ALUCTR_W-1:0] ALU_MULHU  = 5'b01101;
   localparam logic [ALUCTR_W-1:0] ALU_DIV    = 5'b01110;
   localparam logic [ALUCTR_W-1:0] ALU_DIVU   = 5'b01111;
   localparam logic [ALUCTR_W-1:0] ALU_REM    = 5'b10000;
   localparam logic [ALUCTR_W-1:0] ALU_REMU   = 5'b10001;

   typedef enum logic [1:0] {
      MD_IDLE,
      MD_MUL,
      MD_DIV_RUN,
      MD_DIV_FIX
   } muldiv_state_t;

   // M codes occupy one contiguous range
   function automatic logic is_m_op(input logic [ALUCTR_W-1:0] ctrl);
      return (ctrl >= ALU_MUL) && (ctrl <= ALU_REMU);
   endfunction

   function automatic logic is_div_op(input logic [ALUCTR_W-1:0] ctrl);
      return (ctrl >= ALU_DIV) && (ctrl <= ALU_REMU);
   endfunction

   function automatic logic is_rem_op(input logic [ALUCTR_W-1:0] ctrl);
      return (ctrl == ALU_REM) || (ctrl == ALU_REMU);
   endfunction

   function automatic logic is_signed_div(input logic [ALUCTR_W-1:0] ctrl);
      return (ctrl == ALU_DIV) || (ctrl == ALU_REM);
   endfunction

endpackage

// File: rtl/serial_divider.sv
// serial_divider: unsigned restoring divider, one quotient bit per cycle.
//   clk, rst_n  clock, asynchronous active-low reset
//   start       load dividend/divisor, clear remainder, arm XLEN steps
//   flush       abandon the division in progress
//   dividend    unsigned dividend (magnitude)
//   divisor     unsigned divisor (magnitude, non-zero)
//   quotient    quotient register (final after the last step)
//   remainder   remainder register (final after the last step)
//   last        high in the cycle that performs the final step
module serial_divider #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            flush,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder,
   output logic            last
);

   localparam int CW = $clog2(XLEN) + 1;

   logic [CW-1:0]   count;
   logic [XLEN-1:0] quo;
   logic [XLEN-1:0] rem;
   logic [XLEN-1:0] dvs;
   logic [XLEN:0]   trial;

   // The quotient register doubles as the dividend shifter: its MSB feeds
   // the remainder while freshly decided quotient bits enter at the LSB.
   // The shifted remainder needs XLEN+1 bits; a borrow out means "restore".
   always_comb begin
      trial = {rem, quo[XLEN-1]} - {1'b0, dvs};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         quo   <= '0;
         rem   <= '0;
         dvs   <= '0;
      end else if (flush) begin
         count <= '0;
      end else if (start) begin
         quo   <= dividend;
         rem   <= '0;
         dvs   <= divisor;
         count <= CW'(XLEN);
      end else if (count != '0) begin
         count <= count - 1'b1;
         if (!trial[XLEN]) begin
            rem <= trial[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b1};
         end else begin
            rem <= {rem[XLEN-2:0], quo[XLEN-1]};
            quo <= {quo[XLEN-2:0], 1'b0};
         end
      end
   end

   assign quotient  = quo;
   assign remainder = rem;
   assign last      = (count == CW'(1));

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M execute unit (MUL/MULH/MULHSU/MULHU,
// DIV/DIVU/REM/REMU) with a start/busy/done handshake.
//   clk, rst_n  clock, asynchronous active-low reset
//   start       request, accepted when idle and alu_ctrl is an M code
//   alu_ctrl    operation code (alu_pkg M codes)
//   op_a, op_b  rs1 / rs2 operands, latched on acceptance
//   flush       synchronous abort; wins over a same-cycle start
//   busy        operation in flight (state != idle)
//   done        one-cycle completion pulse
//   result      registered result, held until the next completion
module muldiv_unit
   import alu_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int ALUCTR_WIDTH = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [ALUCTR_WIDTH-1:0] alu_ctrl,
   input  logic [XLEN-1:0]         op_a,
   input  logic [XLEN-1:0]         op_b,
   input  logic                    flush,
   output logic                    busy,
   output logic                    done,
   output logic [XLEN-1:0]         result
);

   if (ALUCTR_WIDTH != ALUCTR_W) begin : g_bad_ctrl_width
      $error("muldiv_unit: ALUCTR_WIDTH must match alu_pkg::ALUCTR_W");
   end
   if ((XLEN < 8) || (XLEN % 2 != 0)) begin : g_bad_xlen
      $error("muldiv_unit: XLEN must be even and at least 8");
   end

   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

   muldiv_state_t state, state_d;

   logic [ALUCTR_WIDTH-1:0] ctrl_q;
   logic [XLEN-1:0]         a_q, b_q;
   logic [XLEN-1:0]         result_d;
   logic                    done_d;

   logic                    accept;
   logic                    in_div, in_rem, in_signed;
   logic                    div_zero, div_ovf;
   logic [XLEN-1:0]         fast_res;
   logic                    div_start, div_last;
   logic [XLEN-1:0]         div_dvd, div_dvs, quo, rem;

   logic                    a_sx, b_sx;
   logic [2*XLEN-1:0]       ext_a, ext_b, product;
   logic                    q_signed;
   logic [XLEN-1:0]         fix_quo, fix_rem;

   assign busy = (state != MD_IDLE);

   // Acceptance-cycle decode works on the live inputs
   assign in_div    = is_div_op(alu_ctrl);
   assign in_rem    = is_rem_op(alu_ctrl);
   assign in_signed = is_signed_div(alu_ctrl);
   assign accept    = start && !flush && (state == MD_IDLE) && is_m_op(alu_ctrl);

   assign div_zero  = (op_b == '0);
   assign div_ovf   = in_signed && (op_a == MIN_VAL) && (op_b == '1);
   assign div_start = accept && in_div && !div_zero && !div_ovf;

   always_comb begin
      if (div_zero) fast_res = in_rem ? op_a : '1;
      else          fast_res = in_rem ? '0 : MIN_VAL;
   end

   // Magnitudes; -MIN wraps to MIN, which is the correct unsigned magnitude
   assign div_dvd = (in_signed && op_a[XLEN-1]) ? -op_a : op_a;
   assign div_dvs = (in_signed && op_b[XLEN-1]) ? -op_b : op_b;

   serial_divider #(.XLEN(XLEN)) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (div_start),
      .flush     (flush),
      .dividend  (div_dvd),
      .divisor   (div_dvs),
      .quotient  (quo),
      .remainder (rem),
      .last      (div_last)
   );

   // Extending both operands to 2*XLEN lets one truncated multiply serve
   // signed, mixed and unsigned forms.
   assign a_sx    = (ctrl_q == ALU_MUL) || (ctrl_q == ALU_MULH) || (ctrl_q == ALU_MULHSU);
   assign b_sx    = (ctrl_q == ALU_MUL) || (ctrl_q == ALU_MULH);
   assign ext_a   = {{XLEN{a_sx & a_q[XLEN-1]}}, a_q};
   assign ext_b   = {{XLEN{b_sx & b_q[XLEN-1]}}, b_q};
   assign product = ext_a * ext_b;

   assign q_signed = is_signed_div(ctrl_q);
   assign fix_quo  = (q_signed && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -quo : quo;
   assign fix_rem  = (q_signed && a_q[XLEN-1]) ? -rem : rem;

   always_comb begin
      state_d  = state;
      result_d = result;
      done_d   = 1'b0;
      if (flush) begin
         state_d = MD_IDLE;
      end else begin
         unique case (state)
            MD_IDLE: begin
               if (accept) begin
                  if (!in_div) begin
                     state_d = MD_MUL;
                  end else if (div_start) begin
                     state_d = MD_DIV_RUN;
                  end else begin
                     result_d = fast_res;
                     done_d   = 1'b1;
                  end
               end
            end
            MD_MUL: begin
               result_d = (ctrl_q == ALU_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
               done_d   = 1'b1;
               state_d  = MD_IDLE;
            end
            MD_DIV_RUN: begin
               if (div_last) state_d = MD_DIV_FIX;
            end
            MD_DIV_FIX: begin
               result_d = is_rem_op(ctrl_q) ? fix_rem : fix_quo;
               done_d   = 1'b1;
               state_d  = MD_IDLE;
            end
            default: state_d = MD_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= MD_IDLE;
         result <= '0;
         done   <= 1'b0;
         ctrl_q <= '0;
         a_q    <= '0;
         b_q    <= '0;
      end else begin
         state  <= state_d;
         result <= result_d;
         done   <= done_d;
         if (accept) begin
            ctrl_q <= alu_ctrl;
            a_q    <= op_a;
            b_q    <= op_b;
         end
      end
   end

endmodule
